// File: rtl/wb_status_port.sv
// Wishbone slave that queues firmware status words and paces them onto the status pads, each held HOLD_CYCLES.
// Latency: ack 1 cycle after request; a word pushed into an empty FIFO with EN set reaches status_o 2 cycles after its ack.
// Backpressure: none on the bus; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Optional: STATUS_PORT_SIG_EN adds the pop signature register at 0xC.
module wb_status_port #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [15:0] status_o,
    output logic [15:0] status_oeb_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;
    state_t state, state_nxt;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic [CW-1:0] cnt;
    logic          ctrl_en, ctrl_oe, overflow;
    logic          empty, full, pop, push_req, push_ok;
    logic          req, wr_fire;
    logic [1:0]    reg_sel;
    logic [15:0]   head;
    logic [31:0]   rd_mux, sig_rd;
    logic [3:0]    level4;
    logic          unused_ok;

    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_fire  = wbs_ack_o & wbs_cyc_i & wbs_stb_i & wbs_we_i;
    assign reg_sel  = wbs_adr_i[3:2];
    assign empty    = (level == '0);
    assign full     = (level == (PW+1)'(DEPTH));
    assign head     = mem[rd_ptr];
    assign level4   = 4'(level);
    assign push_req = wr_fire && (reg_sel == 2'd1) && (wbs_sel_i[1:0] == 2'b11);
    // A full FIFO still takes a word when the pacer frees a slot in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign unused_ok = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_en && !empty) state_nxt = ST_HOLD;
            ST_HOLD: if (cnt == '0 && !(ctrl_en && !empty)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = ctrl_en && !empty;
            ST_HOLD: pop = (cnt == '0) && ctrl_en && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            status_o <= 16'h0;
            cnt      <= '0;
        end else if (pop) begin
            status_o <= head;
            cnt      <= CNT_LOAD;
        end else if (state == ST_HOLD && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level <= level + 1'b1;
            else if (pop && !push_ok) level <= level - 1'b1;
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (wr_fire && reg_sel == 2'd2 && wbs_dat_i[6])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr] <= wbs_dat_i[15:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_en <= 1'b0;
            ctrl_oe <= 1'b0;
        end else if (wr_fire && reg_sel == 2'd0) begin
            ctrl_en <= wbs_dat_i[0];
            ctrl_oe <= wbs_dat_i[1];
        end
    end

    assign status_oeb_o = ctrl_oe ? 16'h0000 : 16'hFFFF;

`ifdef STATUS_PORT_SIG_EN
    logic [31:0] sig;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            sig <= '0;
        else if (wr_fire && reg_sel == 2'd3)
            sig <= '0;
        else if (pop)
            sig <= {sig[30:0], sig[31]} ^ {16'h0, head};
    end
    assign sig_rd = sig;
`else
    assign sig_rd = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0:    rd_mux = {30'h0, ctrl_oe, ctrl_en};
            2'd1:    rd_mux = {16'h0, status_o};
            2'd2:    rd_mux = {25'h0, overflow, full, empty, level4};
            default: rd_mux = sig_rd;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_wb_status_port.sv
// Bench for wb_status_port: directed scenarios plus random bus traffic, all scored against a queue-based model.
module tb_wb_status_port;
    localparam int DEPTH = 4;
    localparam int HOLD  = 16;
`ifdef STATUS_PORT_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0, adr = 4'h0;
    logic [31:0] dat = 32'h0;
    logic [31:0] dat_o;
    logic        ack;
    logic [15:0] status_o, status_oeb_o;

    always #5 clk = ~clk;

    wb_status_port #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .status_o(status_o), .status_oeb_o(status_oeb_o)
    );

    int checks = 0, failures = 0;
    int cyc_n = 0;
    int last_ack = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference: FIFO as a queue, pacer as "cycles left on the current word".
    logic [15:0] m_q[$];
    int          m_left = 0;
    logic [15:0] m_stat = 16'h0;
    logic        m_en = 1'b0, m_oe = 1'b0, m_ovf = 1'b0, m_ack = 1'b0;
    logic [31:0] m_sig = 32'h0, m_rdata = 32'h0;

    always @(posedge clk) begin : model
        logic        fire, pop_now;
        logic [31:0] rd;
        logic [15:0] w;
        if (rst) begin
            m_q.delete();
            m_left = 0; m_stat = 16'h0; m_en = 1'b0; m_oe = 1'b0;
            m_ovf = 1'b0; m_ack = 1'b0; m_sig = 32'h0; m_rdata = 32'h0;
        end else begin
            fire = m_ack && cyc && stb;
            case (adr[3:2])
                2'd0:    rd = {30'h0, m_oe, m_en};
                2'd1:    rd = {16'h0, m_stat};
                2'd2:    rd = {25'h0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 4'(m_q.size())};
                default: rd = SIG_EN ? m_sig : 32'h0;
            endcase
            m_rdata = (cyc && stb && !m_ack && !we) ? rd : 32'h0;
            pop_now = m_en && (m_q.size() > 0) && (m_left <= 1);
            if (pop_now) begin
                w = m_q.pop_front();
                m_stat = w;
                m_left = HOLD;
                m_sig = {m_sig[30:0], m_sig[31]} ^ {16'h0, w};
            end else if (m_left > 0) begin
                m_left--;
            end
            if (fire && we) begin
                case (adr[3:2])
                    2'd0: begin m_en = dat[0]; m_oe = dat[1]; end
                    2'd1: if (sel[1:0] == 2'b11) begin
                              if (m_q.size() < DEPTH) m_q.push_back(dat[15:0]);
                              else m_ovf = 1'b1;
                          end
                    2'd2: if (dat[6]) m_ovf = 1'b0;
                    default: m_sig = 32'h0;
                endcase
            end
            m_ack = cyc && stb && !m_ack;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("status", status_o, m_stat);
            chk("oeb", status_oeb_o, m_oe ? 32'h0 : 32'hFFFF);
            chk("ack", ack, m_ack);
            if (m_ack && !we) chk("rdata", dat_o, m_rdata);
        end
    end

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 8);
        chk("wr_ack_wait", n, 1);
        last_ack = cyc_n;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 8);
        chk("rd_ack_wait", n, 1);
        d = dat_o;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_status(input string tag, input logic [15:0] v, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (status_o == v) begin at = cyc_n; break; end
        end
        if (at < 0) begin chk(tag, status_o, v); at = cyc_n; end
    endtask

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc_n < c);
        if (cyc_n != c) chk("sched", cyc_n, c);
    endtask

    logic [15:0] seen[$];
    task automatic collect(input int ncyc);
        seen.delete();
        seen.push_back(status_o);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (status_o != seen[seen.size()-1]) seen.push_back(status_o);
        end
    endtask

    task automatic check_seq(input string tag, input int n,
                             input logic [15:0] e0, e1, e2, e3, e4);
        logic [15:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        chk({tag, "_len"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++) chk(tag, seen[i], e[i]);
    endtask

    initial begin
        logic [31:0] rd;
        int t0, t1;

        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_status", status_o, 16'h0);
        chk("rst_oeb", status_oeb_o, 16'hFFFF);
        chk("rst_ack", ack, 1'b0);
        chk("rst_dat", dat_o, 32'h0);
        rst = 1'b0;
        wb_read(4'h8, rd); chk("rst_stat", rd, 32'h10);
        wb_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);

        // Latency and exact hold period
        wb_write(4'h0, 32'h3, 4'hF);
        wb_write(4'h4, 32'hAB60, 4'hF);
        wait_status("t2_first", 16'hAB60, 10, t0);
        chk("t2_latency", t0 - last_ack, 2);
        wb_write(4'h4, 32'hAB6A, 4'hF);
        wait_status("t2_second", 16'hAB6A, 30, t1);
        chk("t2_hold", t1 - t0, HOLD);
        chk("t2_oeb", status_oeb_o, 16'h0);

        // Overflow with pacer stopped
        wb_write(4'h0, 32'h2, 4'hF);
        for (int i = 1; i <= 5; i++) wb_write(4'h4, i, 4'hF);
        wb_read(4'h8, rd); chk("t3_stat", rd, 32'h64);
        wb_write(4'h0, 32'h3, 4'hF);
        collect(100);
        check_seq("t3_seq", 5, 16'hAB6A, 16'h1, 16'h2, 16'h3, 16'h4);
        wb_write(4'h8, 32'h40, 4'hF);
        wb_read(4'h8, rd); chk("t3_ovf_clr", rd, 32'h10);

        // Push into a full FIFO on the same cycle as a pop
        wb_write(4'h4, 32'h11, 4'hF);
        wait_status("t4_first", 16'h11, 10, t0);
        for (int i = 1; i <= 4; i++) wb_write(4'h4, 32'h20 + i, 4'hF);
        wb_read(4'h8, rd); chk("t4_full", rd, 32'h24);
        wait_until(t0 + HOLD - 3);
        wb_write(4'h4, 32'h77, 4'hF);
        chk("t4_ack_cycle", last_ack, t0 + HOLD - 1);
        wb_read(4'h8, rd); chk("t4_stat", rd, 32'h24);
        collect(120);
        check_seq("t4_seq", 5, 16'h21, 16'h22, 16'h23, 16'h24, 16'h77);

        // Clearing EN mid-hold finishes the hold, then stops
        wb_write(4'h0, 32'h2, 4'hF);
        for (int i = 1; i <= 3; i++) wb_write(4'h4, 32'h30 + i, 4'hF);
        wb_write(4'h0, 32'h3, 4'hF);
        wait_status("t5_first", 16'h31, 10, t0);
        wait_until(t0 + 2);
        wb_write(4'h0, 32'h2, 4'hF);
        wait_until(t0 + HOLD - 1);
        chk("t5_last_hold", status_o, 16'h31);
        wait_until(t0 + 40);
        chk("t5_stopped", status_o, 16'h31);
        wb_read(4'h8, rd); chk("t5_level", rd, 32'h02);
        wb_write(4'h0, 32'h3, 4'hF);
        wait_status("t5_drain", 16'h33, 60, t1);

        // Reset mid-operation
        wb_write(4'h4, 32'h55, 4'hF);
        wb_write(4'h4, 32'h66, 4'hF);
        wait_status("rst_mid_wait", 16'h55, 40, t0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_status", status_o, 16'h0);
        chk("rst_mid_oeb", status_oeb_o, 16'hFFFF);
        rst = 1'b0;
        wb_read(4'h8, rd); chk("rst_mid_stat", rd, 32'h10);
        wb_read(4'h0, rd); chk("rst_mid_ctrl", rd, 32'h0);

        // Signature register (reads 0 when compiled out)
        wb_read(4'hC, rd); chk("sig_rst", rd, 32'h0);
        wb_write(4'h0, 32'h1, 4'hF);
        wb_write(4'h4, 32'h1, 4'hF);
        wait_status("sig_w1", 16'h1, 10, t0);
        wb_read(4'hC, rd); chk("sig_pop1", rd, SIG_EN ? 32'h1 : 32'h0);
        wb_write(4'h4, 32'h2, 4'hF);
        wait_status("sig_w2", 16'h2, 30, t0);
        wb_read(4'hC, rd); chk("sig_pop2", rd, 32'h0);
        wb_write(4'h4, 32'h3, 4'hF);
        wait_status("sig_w3", 16'h3, 30, t0);
        wb_read(4'hC, rd); chk("sig_pop3", rd, SIG_EN ? 32'h3 : 32'h0);
        wb_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        wb_read(4'hC, rd); chk("sig_clr", rd, 32'h0);

        // Random traffic; every cycle is scored by the model
        wb_write(4'h0, 32'h3, 4'hF);
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4)
                wb_write(4'h4, $urandom, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF);
            else if (op == 5)
                wb_write(4'h0, {30'h0, 1'($urandom), 1'($urandom_range(0, 3) != 0)}, 4'hF);
            else if (op == 6)
                wb_read(4'h8, rd);
            else if (op == 7)
                wb_read({2'($urandom), 2'b00}, rd);
            else if (op == 8)
                wb_write({($urandom_range(0, 3) == 0) ? 2'd3 : 2'd2, 2'b00}, $urandom, 4'hF);
            else
                repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
